// File: rtl/mem_pkg.sv
// Shared load/store encodings and access-size decode for the data-memory stage.
package mem_pkg;

    localparam int unsigned MEM_DEPTH_DEFAULT = 256;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LD  = 3'b011,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101,
        F3_LWU = 3'b110,
        F3_ILL = 3'b111
    } funct3_e;

    // Bit 2 only selects signedness, so the size comes from the low two bits.
    function automatic logic [3:0] access_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   access_bytes = 4'd1;
            2'b01:   access_bytes = 4'd2;
            2'b10:   access_bytes = 4'd4;
            default: access_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane extraction: picks the addressed bytes out of an aligned doubleword and extends them.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [63:0] raw_i,
    input  logic [2:0]  funct3_i,
    input  logic [2:0]  offset_i,
    output logic [63:0] data_o
);

    logic [63:0] shifted;

    always_comb begin
        shifted = raw_i >> {offset_i, 3'b000};
        data_o  = '0;
        case (funct3_e'(funct3_i))
            F3_LB:   data_o = {{56{shifted[7]}},  shifted[7:0]};
            F3_LH:   data_o = {{48{shifted[15]}}, shifted[15:0]};
            F3_LW:   data_o = {{32{shifted[31]}}, shifted[31:0]};
            F3_LD:   data_o = shifted;
            F3_LBU:  data_o = {56'd0, shifted[7:0]};
            F3_LHU:  data_o = {48'd0, shifted[15:0]};
            F3_LWU:  data_o = {32'd0, shifted[31:0]};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Data-memory pipeline stage: byte-addressed little-endian RAM with combinational loads,
// edge-triggered stores, alignment/range checking and a sticky error flag.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [63:0] Address,
    input  logic [63:0] Write_Data,
    output logic [63:0] Read_Data,
    output logic        misaligned,
    output logic        out_of_range,
    output logic        mem_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic          mem_err_q, mem_err_d;

    logic [3:0]    size_bytes;
    logic [2:0]    offset;
    logic [AW-1:0] base_addr;
    logic          illegal, misalign_raw, oor_raw, access_ok, access_active;
    logic [63:0]   raw_dword, load_data, wdata_lane;
    logic [7:0]    lane_we;

    assign size_bytes    = access_bytes(funct3);
    assign offset        = Address[2:0];
    assign base_addr     = Address[AW-1:0] & ~AW'(7);
    assign illegal       = (funct3 == F3_ILL);
    assign access_active = MemRead | MemWrite;

    assign misalign_raw  = illegal | ((Address & (64'(size_bytes) - 64'd1)) != 64'd0);
    // Full-width compare so addresses above DEPTH never alias back into the array.
    assign oor_raw       = Address > (64'(DEPTH) - 64'(size_bytes));
    assign access_ok     = ~misalign_raw & ~oor_raw;

    assign misaligned    = access_active & misalign_raw;
    assign out_of_range  = access_active & oor_raw;

    // Aligned accesses never straddle a doubleword, so one aligned fetch serves every size.
    always_comb begin
        raw_dword = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            raw_dword[8*i +: 8] = mem_q[base_addr + AW'(i)];
        end
    end

    mem_load_align u_load_align (
        .raw_i    (raw_dword),
        .funct3_i (funct3),
        .offset_i (offset),
        .data_o   (load_data)
    );

    assign Read_Data = (MemRead & access_ok) ? load_data : '0;

    always_comb begin
        wdata_lane = Write_Data << {offset, 3'b000};
        lane_we    = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if ((4'(i) >= {1'b0, offset}) && (4'(i) < ({1'b0, offset} + size_bytes))) begin
                lane_we[i] = MemWrite & access_ok;
            end
        end
    end

    always_comb begin
        mem_err_d = mem_err_q;
        if (access_active & (misalign_raw | oor_raw)) begin
            mem_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[AW'(i)] <= '0;
            end
            mem_err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (lane_we[i]) begin
                    mem_q[base_addr + AW'(i)] <= wdata_lane[8*i +: 8];
                end
            end
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter DEPTH, default 256, data memory size in bytes (power of two, >= 8).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 MemRead  input  1  load request this cycle.
REQ-005 MemWrite  input  1  store request this cycle.
REQ-006 funct3  input  3  access size/sign: 000 byte, 001 half, 010 word, 011 double, 100 byte-unsigned, 101 half-unsigned, 110 word-unsigned.
REQ-007 Address  input  64  byte address (ALU result from EX_MEM).
REQ-008 Write_Data  input  64  store data; low-order bytes used for sub-word stores.
REQ-009 Read_Data  output  64  load result, sign/zero-extended, consumed by MEM_WB.
REQ-010 misaligned  output  1  combinational: current access is misaligned.
REQ-011 out_of_range  output  1  combinational: current access reaches byte >= DEPTH.
REQ-012 mem_err  output  1  sticky registered error flag.

Function
REQ-013 Memory SHALL be DEPTH bytes, little-endian: byte Address+i holds bits [8i+7:8i].
REQ-014 Read_Data SHALL be combinational from current inputs and memory contents (zero-cycle latency), so MEM_WB captures it on the next edge.
REQ-015 With MemRead=0, Read_Data SHALL be 64'd0.
REQ-016 Loads SHALL sign-extend for funct3 000/001/010 and zero-extend for 100/101/110; 011 returns 64 bits unmodified.
REQ-017 Stores SHALL write on the rising edge with MemWrite=1: 1, 2, 4 or 8 bytes for funct3 low bits 00/01/10/11; funct3 bit 2 ignored for stores.
REQ-018 Access is misaligned when Address is not a multiple of the access size; misaligned SHALL assert that cycle.
REQ-019 Access is out of range when Address + size - 1 >= DEPTH (evaluated on the full 64-bit address, no wrap); out_of_range SHALL assert that cycle.
REQ-020 A misaligned or out-of-range store SHALL write no byte; a misaligned or out-of-range load SHALL return 64'd0.
REQ-021 funct3=111 SHALL be treated as illegal: no write, Read_Data 0, misaligned asserted.
REQ-022 Same-cycle load and store to the same address SHALL return the pre-write (old) data; the new data is visible from the next cycle.
REQ-023 MemRead and MemWrite both high SHALL perform both; error checks apply to the single shared address.
REQ-024 mem_err SHALL be set on the edge following any cycle with (MemRead|MemWrite) and (misaligned|out_of_range), and SHALL hold until reset.
REQ-025 misaligned and out_of_range SHALL be 0 when MemRead=MemWrite=0.

Reset
REQ-026 On a rising edge with reset=1, all memory bytes SHALL become 8'h00 and mem_err 0; any store that same cycle SHALL be discarded.
REQ-027 Reset asserted mid-sequence SHALL take priority over MemWrite; stores resume the first edge after reset deasserts.
REQ-028 During reset, Read_Data SHALL reflect current (possibly pre-clear) contents; after the reset edge, loads return 0.

Structure
REQ-029 funct3 encodings and size decode constants SHALL live in shared package mem_pkg, with DEPTH default.
REQ-030 Load extraction and sign/zero extension SHALL be a combinational sub-module mem_load_align (inputs: 8 raw bytes, funct3, offset; output: 64-bit result).
REQ-031 Byte array storage and store-enable logic SHALL remain in mem_stage.

Verification
REQ-032 Reset, then sd 64'h8877_6655_4433_2211 at 0x10; next cycle ld 0x10 -> 64'h8877_6655_4433_2211; lb 0x17 -> 64'hFFFF_FFFF_FFFF_FF88; lbu 0x17 -> 64'h88.
REQ-033 sw 32'hDEAD_BEEF at 0x20, then lw 0x20 -> 64'hFFFF_FFFF_DEAD_BEEF; lwu 0x20 -> 64'h0000_0000_DEAD_BEEF; ld 0x20 upper word 0.
REQ-034 sh at 0x21 -> misaligned=1 that cycle, memory unchanged, mem_err=1 next cycle and remains 1 until reset.
REQ-035 ld at DEPTH-4 -> out_of_range=1, Read_Data=0; ld at DEPTH-8 -> valid, out_of_range=0; sd at 64'h1_0000_0000 -> no write (no wrap to 0).
REQ-036 Same cycle MemRead=MemWrite=1, ld/sd at 0x08 with old 0x0 and new 0x55 -> Read_Data=0 that cycle, 0x55 next cycle.
REQ-037 sd 0xAA at 0x00 with reset=1 same edge -> ld 0x00 afterwards returns 0, mem_err=0.
